// File: rtl/ifu_fetch_pkg.sv
// rtl/ifu_fetch_pkg.sv - shared constants and types for the instruction fetch unit
package ifu_fetch_pkg;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - fetch buffer of {addr, inst} entries with push/pop/flush
module ifu_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_push = push_i && (count_q != CW'(DEPTH));
    do_pop  = pop_i && (count_q != '0);
    // Flush wins over a same-cycle push or pop.
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = push_data_i;
        wptr_d        = wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch stage: PC, credit-limited bus requests, redirect flush
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [31:0]   aq_q [FIFO_DEPTH];
  logic [31:0]   aq_d [FIFO_DEPTH];
  logic [AW-1:0] aq_wr_q, aq_wr_d;
  logic [AW-1:0] aq_rd_q, aq_rd_d;

  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   in_use;
  logic          pop, grant, resp, push;

  always_comb begin
    inst_valid_o = (fifo_count != '0);
    pop          = inst_valid_o & ~hold_i & ~jump_flag_i;
    // Buffered plus in-flight words may never exceed the buffer size.
    in_use       = {1'b0, fifo_count} + {1'b0, out_q} - (CW + 1)'(pop);
    ibus_req_o   = rst_n & (in_use < (CW + 1)'(FIFO_DEPTH));
    grant        = ibus_req_o & ibus_gnt_i;
    resp         = ibus_rvalid_i & (out_q != '0);
    push         = resp & (disc_q == '0) & ~jump_flag_i;
    push_data    = '{addr: aq_q[aq_rd_q], inst: ibus_rdata_i};

    ibus_addr_o  = pc_q;
    inst_o       = inst_valid_o ? head.inst : INST_NOP;
    inst_addr_o  = inst_valid_o ? head.addr : ZERO_WORD;
  end

  always_comb begin
    pc_d    = pc_q;
    out_d   = out_q + CW'(grant) - CW'(resp);
    disc_d  = disc_q;
    aq_d    = aq_q;
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;

    if (jump_flag_i) begin
      pc_d   = word_align(jump_addr_i);
      disc_d = out_d;
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (resp && (disc_q != '0)) begin
        disc_d = disc_q - CW'(1);
      end
    end

    // Grant addresses are queued in bus order, independent of discard.
    if (grant) begin
      aq_d[aq_wr_q] = pc_q;
      aq_wr_d       = aq_wr_q + AW'(1);
    end
    if (resp) begin
      aq_rd_d = aq_rd_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      out_q   <= '0;
      disc_q  <= '0;
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        aq_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      aq_wr_q <= aq_wr_d;
      aq_rd_q <= aq_rd_d;
      aq_q    <= aq_d;
    end
  end

  ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (jump_flag_i),
    .head_o     (head),
    .count_o    (fifo_count)
  );

endmodule
